pixel_frame_sequencer: RTL and testbench

// Parametrised frame sequencer for the pixel-sensor array: erase, expose, convert, then per-row readout.

---
 rtl/pixel_frame_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_pixel_frame_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer
// Frame sequencer for the pixel-sensor array. Each frame runs four phases:
// erase, expose, convert, then a one-hot read of every row in order.
// The block can run a single frame or chain frames back to back.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high; release is synchronised internally
//   start      - request one frame (only honoured while idle)
//   continuous - sampled on the last read cycle: 1 chains straight into a new frame
//   exp_cycles - exposure length in cycles (0 behaves as 1), latched when a frame starts
//   erase, expose, convert - phase strobes (at most one high at a time)
//   read       - one-hot row read select
//   cnt_en     - tri-state enable for cnt_data onto the shared pixData bus
//   cnt_data   - conversion counter (saturating)
//   read_valid - pixData valid for row read_row on this cycle
//   read_row   - index of the row being read (0 outside the read phase)
//   busy       - high whenever a frame is in progress
//   frame_done - one-cycle pulse on the final read cycle of a frame
module pixel_frame_sequencer #(
    parameter int N_ROWS    = 4,
    parameter int DATA_W    = 8,
    parameter int EXP_W     = 16,
    parameter int ERASE_CYC = 5,
    parameter int CONV_CYC  = 256,
    parameter int READ_CYC  = 2,
    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic [EXP_W-1:0]  exp_cycles,
    output logic              erase,
    output logic              expose,
    output logic              convert,
    output logic [N_ROWS-1:0] read,
    output logic              cnt_en,
    output logic [DATA_W-1:0] cnt_data,
    output logic              read_valid,
    output logic [RW-1:0]     read_row,
    output logic              busy,
    output logic              frame_done
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The phase counter must hold the longest phase, including the largest exposure.
    localparam int PW = max2(max2(EXP_W, $clog2(CONV_CYC + 1)),
                             max2($clog2(ERASE_CYC + 1), $clog2(READ_CYC + 1)));

    function automatic logic [N_ROWS-1:0] row_hot(input logic [RW-1:0] r);
        logic [N_ROWS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } state_t;

    state_t            state_r;
    logic [PW-1:0]     phase_r;
    logic [EXP_W-1:0]  exp_q_r;
    logic [1:0]        rst_sync_r;
    logic              rst_int_s;
    logic [EXP_W-1:0]  exp_lat_s;
    logic [DATA_W-1:0] cnt_next_s;
    logic [PW-1:0]     phase_inc_s;
    logic [RW-1:0]     next_row_s;
    logic              last_row_s;

    // Reset release synchroniser: assertion is immediate, release waits two clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync_r <= 2'b11;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b0};
        end
    end

    assign rst_int_s = rst_sync_r[1];

    // Helper values for the sequencer: latched exposure, saturating count, row stepping.
    always_comb begin
        exp_lat_s   = (exp_cycles == {EXP_W{1'b0}}) ? EXP_W'(1) : exp_cycles;
        cnt_next_s  = (cnt_data == {DATA_W{1'b1}}) ? cnt_data : cnt_data + DATA_W'(1);
        phase_inc_s = phase_r + PW'(1);
        next_row_s  = read_row + RW'(1);
        last_row_s  = (read_row == RW'(N_ROWS - 1));
    end

    // Frame sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst_int_s) begin
        if (rst_int_s) begin
            state_r    <= ST_IDLE;
            phase_r    <= '0;
            exp_q_r    <= '0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read       <= '0;
            cnt_en     <= 1'b0;
            cnt_data   <= '0;
            read_valid <= 1'b0;
            read_row   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r  <= ST_ERASE;
                        phase_r  <= '0;
                        exp_q_r  <= exp_lat_s;
                        erase    <= 1'b1;
                        busy     <= 1'b1;
                        cnt_data <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ERASE: begin
                    if (phase_r == PW'(ERASE_CYC - 1)) begin
                        state_r <= ST_EXPOSE;
                        phase_r <= '0;
                        erase   <= 1'b0;
                        expose  <= 1'b1;
                    end else begin
                        phase_r <= phase_inc_s;
                    end
                end
                ST_EXPOSE: begin
                    if (phase_inc_s == PW'(exp_q_r)) begin
                        state_r <= ST_CONVERT;
                        phase_r <= '0;
                        expose  <= 1'b0;
                        convert <= 1'b1;
                        cnt_en  <= 1'b1;
                    end else begin
                        phase_r <= phase_inc_s;
                    end
                end
                ST_CONVERT: begin
                    if (phase_r == PW'(CONV_CYC - 1)) begin
                        state_r    <= ST_READ;
                        phase_r    <= '0;
                        convert    <= 1'b0;
                        cnt_en     <= 1'b0;
                        read       <= row_hot(RW'(0));
                        read_row   <= '0;
                        // Single-cycle row slots are valid (and possibly final) immediately.
                        read_valid <= (READ_CYC == 1);
                        frame_done <= (READ_CYC == 1) && (N_ROWS == 1);
                    end else begin
                        phase_r  <= phase_inc_s;
                        cnt_data <= cnt_next_s;
                    end
                end
                ST_READ: begin
                    if (phase_r == PW'(READ_CYC - 1)) begin
                        phase_r <= '0;
                        if (last_row_s) begin
                            read       <= '0;
                            read_row   <= '0;
                            read_valid <= 1'b0;
                            frame_done <= 1'b0;
                            if (continuous) begin
                                state_r  <= ST_ERASE;
                                exp_q_r  <= exp_lat_s;
                                erase    <= 1'b1;
                                cnt_data <= '0;
                            end else begin
                                state_r <= ST_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            read_row   <= next_row_s;
                            read       <= row_hot(next_row_s);
                            read_valid <= (READ_CYC == 1);
                            frame_done <= (READ_CYC == 1) && (next_row_s == RW'(N_ROWS - 1));
                        end
                    end else begin
                        phase_r    <= phase_inc_s;
                        read_valid <= (phase_inc_s == PW'(READ_CYC - 1));
                        frame_done <= (phase_inc_s == PW'(READ_CYC - 1)) && last_row_s;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    phase_r    <= '0;
                    erase      <= 1'b0;
                    expose     <= 1'b0;
                    convert    <= 1'b0;
                    read       <= '0;
                    cnt_en     <= 1'b0;
                    read_valid <= 1'b0;
                    read_row   <= '0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Testbench for pixel_frame_sequencer with default parameters.
// Expected outputs are derived from the cycle offset within a frame using
// the phase lengths (erase, exposure, conversion, per-row read slots).
module tb_pixel_frame_sequencer;

    localparam int ER = 5;
    localparam int CV = 256;
    localparam int RC = 2;
    localparam int NR = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        continuous;
    logic [15:0] exp_cycles;
    logic        erase;
    logic        expose;
    logic        convert;
    logic [3:0]  read;
    logic        cnt_en;
    logic [7:0]  cnt_data;
    logic        read_valid;
    logic [1:0]  read_row;
    logic        busy;
    logic        frame_done;

    int n_checks;
    int n_fail;
    int last_cnt;

    pixel_frame_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .exp_cycles (exp_cycles),
        .erase      (erase),
        .expose     (expose),
        .convert    (convert),
        .read       (read),
        .cnt_en     (cnt_en),
        .cnt_data   (cnt_data),
        .read_valid (read_valid),
        .read_row   (read_row),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] observed();
        return {erase, expose, convert, read, cnt_en, cnt_data, read_valid, read_row, busy, frame_done};
    endfunction

    task automatic chk(input string tag, input logic [20:0] o, input logic [20:0] x);
        n_checks++;
        assert (o === x) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    task automatic check_idle(input int n);
        logic [20:0] x;
        for (int i = 0; i < n; i++) begin
            x = {8'b0, 8'(last_cnt), 5'b0};
            chk("idle", observed(), x);
            @(negedge clk);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called while the first frame cycle is visible. Checks every cycle of the
    // frame; optional pokes: start at s1/s2, new exposure at et, clear
    // continuous at ct, assert reset at at (then returns immediately).
    task automatic check_frame(input int e, input int s1, input int s2,
                               input int et, input logic [15:0] ev,
                               input int ct, input int at);
        int conv0, rd0, len, r, row, cv;
        logic [3:0]  rd;
        logic [20:0] x;
        conv0 = ER + e;
        rd0   = conv0 + CV;
        len   = rd0 + NR * RC;
        for (int t = 0; t < len; t++) begin
            if (t < conv0) cv = 0;
            else if (t < rd0) cv = (t - conv0 > 255) ? 255 : t - conv0;
            else cv = (CV - 1 > 255) ? 255 : CV - 1;
            r   = t - rd0;
            row = (t >= rd0) ? r / RC : 0;
            rd  = (t >= rd0) ? 4'(1 << row) : 4'b0;
            x = {(t < ER), (t >= ER && t < conv0), (t >= conv0 && t < rd0), rd,
                 (t >= conv0 && t < rd0), 8'(cv),
                 (t >= rd0 && (r % RC) == RC - 1), 2'(row), 1'b1,
                 (t == len - 1)};
            chk($sformatf("frame e=%0d t=%0d", e, t), observed(), x);
            if (t == at) begin
                reset = 1'b1;
                #1;
                chk("async_reset", observed(), 21'b0);
                last_cnt = 0;
                return;
            end
            start = (t == s1 || t == s2);
            if (t == et) exp_cycles = ev;
            if (t == ct) continuous = 1'b0;
            @(negedge clk);
        end
        start    = 1'b0;
        last_cnt = (CV - 1 > 255) ? 255 : CV - 1;
    endtask

    initial begin
        int e, e2;
        n_checks   = 0;
        n_fail     = 0;
        last_cnt   = 0;
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        exp_cycles = 16'd0;

        // Reset held 3 cycles, then 20 idle cycles with start low.
        @(negedge clk);
        check_idle(3);
        reset = 1'b0;
        check_idle(20);

        // Single frame, exposure 10 (279 cycles).
        exp_cycles = 16'd10;
        do_start();
        check_frame(10, -1, -1, -1, 16'd0, -1, -1);
        check_idle(5);

        // Exposure 0 behaves as 1 (270 cycles).
        exp_cycles = 16'd0;
        do_start();
        check_frame(1, -1, -1, -1, 16'd0, -1, -1);
        check_idle(4);

        // Continuous: exposure changed mid-expose, used only by frame 2; cleared in frame 2.
        exp_cycles = 16'd10;
        continuous = 1'b1;
        do_start();
        check_frame(10, -1, -1, 7, 16'd3, -1, -1);
        check_frame(3, -1, -1, -1, 16'd0, 5, -1);
        check_idle(10);

        // Start during expose and on the frame_done cycle is ignored.
        exp_cycles = 16'd6;
        do_start();
        check_frame(6, 8, ER + 6 + CV + NR * RC - 1, -1, 16'd0, -1, -1);
        check_idle(10);

        // Reset mid-convert at cnt_data=100, then a clean frame.
        exp_cycles = 16'd4;
        do_start();
        check_frame(4, -1, -1, -1, 16'd0, -1, ER + 4 + 100);
        @(negedge clk);
        check_idle(2);
        reset = 1'b0;
        check_idle(6);
        exp_cycles = 16'd2;
        do_start();
        check_frame(2, -1, -1, -1, 16'd0, -1, -1);
        check_idle(3);

        // Randomised single frames.
        for (int i = 0; i < 3; i++) begin
            e = int'($urandom_range(0, 15));
            exp_cycles = 16'(e);
            do_start();
            check_frame((e == 0) ? 1 : e, -1, -1, -1, 16'd0, -1, -1);
            check_idle(int'($urandom_range(2, 6)));
        end

        // Randomised continuous pair.
        e  = int'($urandom_range(1, 12));
        e2 = int'($urandom_range(0, 12));
        exp_cycles = 16'(e);
        continuous = 1'b1;
        do_start();
        check_frame(e, -1, -1, 2, 16'(e2), -1, -1);
        check_frame((e2 == 0) ? 1 : e2, -1, -1, -1, 16'd0, 1, -1);
        check_idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
